// File: rtl/cpu_flow_ctrl.sv
// cpu_flow_ctrl -- instruction decode and program-flow unit of the 8-bit
// single-cycle CPU.
//
// Decodes the opcode into datapath control strobes, forms the sequential
// (pc + 4) and jump/branch target addresses, picks the next PC and holds the
// 32-bit program counter.
//
// Optional feature: define CPU_FLOW_BNE_EN to add the bne instruction
// (opcode 0x08). Without it, 0x08 decodes as an undefined opcode (NOP).
//
// Ports:
//   clk        in   1   system clock, rising-edge active
//   reset      in   1   synchronous, active-high; clears pc
//   opcode     in   8   instruction[31:24]
//   offset     in   8   instruction[23:16], signed word offset
//   zero       in   1   ALU zero flag of the current instruction
//   pc         out  32  program counter (registered)
//   pc_plus4   out  32  pc + 4 (combinational)
//   target     out  32  pc_plus4 + sign_extend(offset) * 4 (combinational)
//   writeable  out  1   register-file write enable
//   aluop      out  3   ALU function select
//   mux1op     out  1   1 = two's-complement of operand 2
//   mux2op     out  1   1 = immediate as operand 2
//   jump       out  1   unconditional jump decoded
//   branch     out  1   beq decoded
//   flowselect out  1   1 = next pc is target
//
// There is no handshake: one instruction completes every clock cycle, and
// every output except pc follows its inputs combinationally.
module cpu_flow_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  opcode,
  input  logic [7:0]  offset,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        writeable,
  output logic [2:0]  aluop,
  output logic        mux1op,
  output logic        mux2op,
  output logic        jump,
  output logic        branch,
  output logic        flowselect
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
`ifdef CPU_FLOW_BNE_EN
  localparam logic [7:0] OP_BNE   = 8'h08;
`endif

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  logic [31:0] offset_bytes;

`ifdef CPU_FLOW_BNE_EN
  logic branch_ne;
`endif

  // Decode: every strobe defaults to 0 so undefined opcodes are NOPs.
  always_comb begin
    writeable = 1'b0;
    aluop     = ALU_FWD;
    mux1op    = 1'b0;
    mux2op    = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
`ifdef CPU_FLOW_BNE_EN
    branch_ne = 1'b0;
`endif
    case (opcode)
      OP_LOADI: begin writeable = 1'b1; mux2op = 1'b1; end
      OP_MOV:   begin writeable = 1'b1; end
      OP_ADD:   begin writeable = 1'b1; aluop = ALU_ADD; end
      OP_SUB:   begin writeable = 1'b1; aluop = ALU_ADD; mux1op = 1'b1; end
      OP_AND:   begin writeable = 1'b1; aluop = ALU_AND; end
      OP_OR:    begin writeable = 1'b1; aluop = ALU_OR; end
      OP_J:     begin jump = 1'b1; end
      // beq subtracts operands in the ALU; zero reports equality.
      OP_BEQ:   begin aluop = ALU_ADD; mux1op = 1'b1; branch = 1'b1; end
`ifdef CPU_FLOW_BNE_EN
      // bne keeps the visible branch strobe low; only the internal term fires.
      OP_BNE:   begin aluop = ALU_ADD; mux1op = 1'b1; branch_ne = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Word offset -> byte offset: sign-extend and scale by 4.
  assign offset_bytes = {{22{offset[7]}}, offset, 2'b00};
  assign pc_plus4     = pc + 32'd4;
  assign target       = pc_plus4 + offset_bytes;

`ifdef CPU_FLOW_BNE_EN
  assign flowselect = jump | (branch & zero) | (branch_ne & ~zero);
`else
  assign flowselect = jump | (branch & zero);
`endif

  // Reset has priority over any flow decision on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 32'h0000_0000;
    end else if (flowselect) begin
      pc <= target;
    end else begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_cpu_flow_ctrl.sv
// Testbench for cpu_flow_ctrl: table-driven decode vectors plus hand-written
// multi-cycle sequences for reset, jump, branch, bne and wrap-around.
module tb_cpu_flow_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  opcode;
  logic [7:0]  offset;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        writeable;
  logic [2:0]  aluop;
  logic        mux1op;
  logic        mux2op;
  logic        jump;
  logic        branch;
  logic        flowselect;

  always #5 clk = ~clk;

  cpu_flow_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .offset     (offset),
    .zero       (zero),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .target     (target),
    .writeable  (writeable),
    .aluop      (aluop),
    .mux1op     (mux1op),
    .mux2op     (mux2op),
    .jump       (jump),
    .branch     (branch),
    .flowselect (flowselect)
  );

  // ---------------- scoreboard ----------------
  int applied = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Pops the next expected pc from the queue and compares it.
  task automatic check_pc_q(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      applied++;
      errors++;
      $display("FAIL %s: expected-queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, pc, e);
    end
  endtask

  // ---------------- drivers ----------------
  // One clock edge; outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then run n mov instructions so pc = 4*n.
  task automatic goto_pc(input int n);
    reset  = 1'b1;
    opcode = 8'h01;
    offset = 8'h00;
    zero   = 1'b0;
    step();
    reset = 1'b0;
    repeat (n) step();
    check("goto_pc", pc, 32'(4 * n));
  endtask

  task automatic drive(input logic [7:0] op, input logic [7:0] off, input logic z);
    opcode = op;
    offset = off;
    zero   = z;
    #1;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [7:0] op;
    logic       z;
    logic [8:0] exp;  // {writeable, aluop[2:0], mux1op, mux2op, jump, branch, flowselect}
  } dec_vec_t;

  dec_vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'h00, 1'b0, 9'b1_000_0_1_0_0_0};
    vecs[1]  = '{8'h01, 1'b0, 9'b1_000_0_0_0_0_0};
    vecs[2]  = '{8'h02, 1'b0, 9'b1_001_0_0_0_0_0};
    vecs[3]  = '{8'h03, 1'b0, 9'b1_001_1_0_0_0_0};
    vecs[4]  = '{8'h04, 1'b0, 9'b1_010_0_0_0_0_0};
    vecs[5]  = '{8'h05, 1'b0, 9'b1_011_0_0_0_0_0};
    vecs[6]  = '{8'h06, 1'b0, 9'b0_000_0_0_1_0_1};
    vecs[7]  = '{8'h07, 1'b0, 9'b0_001_1_0_0_1_0};
    vecs[8]  = '{8'h07, 1'b1, 9'b0_001_1_0_0_1_1};
    vecs[9]  = '{8'hFF, 1'b1, 9'b0_000_0_0_0_0_0};
`ifdef CPU_FLOW_BNE_EN
    vecs[10] = '{8'h08, 1'b0, 9'b0_001_1_0_0_0_1};
    vecs[11] = '{8'h08, 1'b1, 9'b0_001_1_0_0_0_0};
`else
    vecs[10] = '{8'h08, 1'b0, 9'b0_000_0_0_0_0_0};
    vecs[11] = '{8'h08, 1'b1, 9'b0_000_0_0_0_0_0};
`endif
  end

  // ---------------- test sequence ----------------
  initial begin
    reset  = 1'b1;
    opcode = 8'h06;
    offset = 8'h05;
    zero   = 1'b0;
    #2;

    // Reset held for two edges with a jump on the inputs.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    step(); check_pc_q("reset_edge1");
    step(); check_pc_q("reset_edge2");

    // Decode sweep while reset holds pc at 0 (pc_plus4 = 4, target = 4 + 5*4).
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, 8'h05, vecs[i].z);
      check($sformatf("decode_op%02h_z%0d", vecs[i].op, vecs[i].z),
            {23'd0, writeable, aluop, mux1op, mux2op, jump, branch, flowselect},
            {23'd0, vecs[i].exp});
    end
    check("pc_plus4_at0", pc_plus4, 32'h4);
    check("target_at0", target, 32'h18);

    // Release reset, add steps 0 -> 4 -> 8.
    drive(8'h02, 8'h05, 1'b0);
    reset = 1'b0;
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    step(); check_pc_q("run_step1");
    step(); check_pc_q("run_step2");

    // Jump forward: pc 0x10, offset +2 -> 0x1C.
    goto_pc(4);
    drive(8'h06, 8'h02, 1'b0);
    check("jump_target", target, 32'h1C);
    check("jump_flowsel", {31'd0, flowselect}, 32'd1);
    step();
    check("jump_fwd_pc", pc, 32'h1C);

    // Jump backward: pc 0x10, offset -2 -> 0x0C.
    goto_pc(4);
    drive(8'h06, 8'hFE, 1'b0);
    step();
    check("jump_back_pc", pc, 32'h0C);

    // beq taken / not taken at pc 0x20.
    goto_pc(8);
    drive(8'h07, 8'h01, 1'b1);
    step();
    check("beq_taken_pc", pc, 32'h28);
    goto_pc(8);
    drive(8'h07, 8'h01, 1'b0);
    step();
    check("beq_not_taken_pc", pc, 32'h24);

    // bne at pc 0x20.
    goto_pc(8);
    drive(8'h08, 8'h01, 1'b0);
    check("bne_writeable", {31'd0, writeable}, 32'd0);
    step();
`ifdef CPU_FLOW_BNE_EN
    check("bne_z0_pc", pc, 32'h28);
`else
    check("bne_z0_pc", pc, 32'h24);
`endif
    goto_pc(8);
    drive(8'h08, 8'h01, 1'b1);
    step();
    check("bne_z1_pc", pc, 32'h24);

    // Wrap: from pc 0, jump -2 words -> 0xFFFF_FFFC, then mov -> 0.
    goto_pc(0);
    drive(8'h06, 8'hFE, 1'b0);
    step();
    check("wrap_jump_pc", pc, 32'hFFFF_FFFC);
    drive(8'h01, 8'h01, 1'b0);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    check("wrap_target", target, 32'h4);
    step();
    check("wrap_seq_pc", pc, 32'h0);

    // Reset asserted mid-program beats a pending jump.
    goto_pc(3);
    drive(8'h06, 8'h10, 1'b0);
    reset = 1'b1;
    step();
    check("reset_mid_pc", pc, 32'h0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

  // Watchdog: the sequence above needs well under a few hundred cycles.
  initial begin
    #20000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
